// File: rtl/jtframe_romarb_pkg.sv
// rtl/jtframe_romarb_pkg.sv - shared types, constants and helpers for the ROM read arbiter
package jtframe_romarb_pkg;

  localparam int SDRAM_AW  = 22;
  localparam int MAX_SLOTS = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  // Slot idx's word offset inside a packed offset vector widened to MAX_SLOTS entries
  function automatic logic [SDRAM_AW-1:0] slot_offset(
    input logic [MAX_SLOTS*SDRAM_AW-1:0] offsets,
    input int                            idx
  );
    return offsets[idx*SDRAM_AW +: SDRAM_AW];
  endfunction

endpackage

// File: rtl/jtframe_romarb_slot.sv
// rtl/jtframe_romarb_slot.sv - one-word read cache, hit detect and registered slot_ok for one slot
module jtframe_romarb_slot
  import jtframe_romarb_pkg::*;
#(
  parameter int SAW = 19,
  parameter bit IS8 = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           downloading,
  input  logic           cs,
  input  logic [SAW-1:0] addr,
  input  logic           fill_en,
  input  logic [SAW-1:0] fill_tag,
  input  logic [15:0]    fill_data,
  output logic [SAW-1:0] wa,
  output logic           miss,
  output logic           ok,
  output logic [15:0]    dout
);

  logic           valid_q, valid_d;
  logic [SAW-1:0] tag_q, tag_d;
  logic [15:0]    data_q, data_d;
  logic           ok_q, ok_d;
  logic [15:0]    dout_q, dout_d;
  logic           hit, fwd;

  // 8-bit slots return the addressed byte zero-extended; 16-bit slots the whole word
  function automatic logic [15:0] lane(input logic [15:0] w, input logic b0);
    if (!IS8) return w;
    return b0 ? {8'h00, w[15:8]} : {8'h00, w[7:0]};
  endfunction

  assign wa   = IS8 ? (addr >> 1) : addr;
  assign hit  = cs & valid_q & (tag_q == wa);
  // Forwarding the fill word lets slot_ok rise the cycle right after data_rdy
  assign fwd  = cs & fill_en & (fill_tag == wa);
  assign miss = cs & ~hit;
  assign ok   = ok_q;
  assign dout = dout_q;

  // Cache update, download flush and next slot_ok/slot_dout
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    ok_d    = 1'b0;
    dout_d  = dout_q;
    if (downloading) begin
      valid_d = 1'b0;
    end else begin
      if (fill_en) begin
        valid_d = 1'b1;
        tag_d   = fill_tag;
        data_d  = fill_data;
      end
      if (hit) begin
        ok_d   = 1'b1;
        dout_d = lane(data_q, addr[0]);
      end else if (fwd) begin
        ok_d   = 1'b1;
        dout_d = lane(fill_data, addr[0]);
      end
    end
  end

  // Cache and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
      ok_q    <= 1'b0;
      dout_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      ok_q    <= ok_d;
      dout_q  <= dout_d;
    end
  end

endmodule

// File: rtl/jtframe_romarb.sv
// rtl/jtframe_romarb.sv - N-slot cached SDRAM read arbiter with fixed-priority or round-robin grant
module jtframe_romarb
  import jtframe_romarb_pkg::*;
#(
  parameter int                         SLOTS   = 4,
  parameter int                         SAW     = 19,
  parameter logic [SLOTS-1:0]           DW8     = '0,
  parameter logic [SLOTS*SDRAM_AW-1:0]  OFFSETS = '0,
  parameter bit                         RR      = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  downloading,
  input  logic [SLOTS-1:0]      slot_cs,
  input  logic [SLOTS*SAW-1:0]  slot_addr,
  output logic [SLOTS-1:0]      slot_ok,
  output logic [SLOTS*16-1:0]   slot_dout,
  output logic                  sdram_req,
  output logic [SDRAM_AW-1:0]   sdram_addr,
  input  logic                  sdram_ack,
  input  logic                  data_rdy,
  input  logic [15:0]           data_read
);

  localparam int GW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [MAX_SLOTS*SDRAM_AW-1:0] OFF_ALL = (MAX_SLOTS*SDRAM_AW)'(OFFSETS);

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic [SDRAM_AW-1:0] addr_q, addr_d;
  logic [SAW-1:0]      tag_q, tag_d;
  logic [GW-1:0]       gnt_q, gnt_d;
  logic [GW-1:0]       last_q, last_d;
  logic                discard_q, discard_d;
  logic                fill, fill_en;
  logic                arb_found;
  logic [GW-1:0]       arb_idx, arb_scan;
  logic [SDRAM_AW-1:0] arb_addr;
  logic [SLOTS-1:0]    miss;
  logic [SAW-1:0]      wa [SLOTS];

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    jtframe_romarb_slot #(
      .SAW (SAW),
      .IS8 (DW8[i])
    ) u_slot (
      .clk         (clk),
      .rst         (rst),
      .downloading (downloading),
      .cs          (slot_cs[i]),
      .addr        (slot_addr[i*SAW +: SAW]),
      .fill_en     (fill_en && (gnt_q == GW'(i))),
      .fill_tag    (tag_q),
      .fill_data   (data_read),
      .wa          (wa[i]),
      .miss        (miss[i]),
      .ok          (slot_ok[i]),
      .dout        (slot_dout[i*16 +: 16])
    );
  end

  // Pick the winning missing slot: lowest index, or first after last_grant in round-robin
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_scan  = '0;
    for (int k = 0; k < SLOTS; k++) begin
      arb_scan = RR ? GW'((int'(last_q) + 1 + k) % SLOTS) : GW'(k);
      if (!arb_found && miss[arb_scan]) begin
        arb_found = 1'b1;
        arb_idx   = arb_scan;
      end
    end
    arb_addr = SDRAM_AW'(wa[arb_idx]) + slot_offset(OFF_ALL, int'(arb_idx));
  end

  // A fill seen while downloading (or after it started mid-transaction) is dropped
  assign fill_en    = fill & ~discard_q & ~downloading;
  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;

  // Request/ack/ready sequencing of the shared SDRAM read port
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    addr_d    = addr_q;
    tag_d     = tag_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    discard_d = discard_q;
    fill      = 1'b0;
    case (state_q)
      IDLE: begin
        discard_d = 1'b0;
        if (arb_found && !downloading) begin
          gnt_d   = arb_idx;
          last_d  = arb_idx;
          addr_d  = arb_addr;
          tag_d   = wa[arb_idx];
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        discard_d = discard_q | downloading;
        if (sdram_ack) begin
          req_d = 1'b0;
          if (data_rdy) begin
            fill    = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        discard_d = discard_q | downloading;
        if (data_rdy) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and latched request registers; reset abandons any open request at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      addr_q    <= '0;
      tag_q     <= '0;
      gnt_q     <= '0;
      last_q    <= GW'(SLOTS - 1);
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      tag_q     <= tag_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      discard_q <= discard_d;
    end
  end

endmodule

// File: tb/tb_jtframe_romarb.sv
// tb/tb_jtframe_romarb.sv - directed self-checking bench for jtframe_romarb
module tb_jtframe_romarb;

  localparam int SAW = 19;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]       cs   [2];
  logic [4*SAW-1:0] addr [2];
  logic             dl   [2];
  logic             ack  [2];
  logic             rdy  [2];
  logic [15:0]      rd   [2];
  logic [3:0]       ok   [2];
  logic [63:0]      dout [2];
  logic             req  [2];
  logic [21:0]      sa   [2];

  int n_vec = 0;
  int n_err = 0;

  // Round-robin instance: slot 1 is 8-bit, slot 3 offset wraps past 22 bits
  jtframe_romarb #(
    .SLOTS(4), .SAW(SAW), .DW8(4'b0010),
    .OFFSETS({22'h3FFFF0, 22'h003000, 22'h002000, 22'h001000}), .RR(1'b1)
  ) u_rr (
    .clk(clk), .rst(rst), .downloading(dl[0]), .slot_cs(cs[0]), .slot_addr(addr[0]),
    .slot_ok(ok[0]), .slot_dout(dout[0]), .sdram_req(req[0]), .sdram_addr(sa[0]),
    .sdram_ack(ack[0]), .data_rdy(rdy[0]), .data_read(rd[0])
  );

  // Fixed-priority instance, all 16-bit, no offsets
  jtframe_romarb #(
    .SLOTS(4), .SAW(SAW), .DW8(4'b0000), .OFFSETS(88'd0), .RR(1'b0)
  ) u_fp (
    .clk(clk), .rst(rst), .downloading(dl[1]), .slot_cs(cs[1]), .slot_addr(addr[1]),
    .slot_ok(ok[1]), .slot_dout(dout[1]), .sdram_req(req[1]), .sdram_addr(sa[1]),
    .sdram_ack(ack[1]), .data_rdy(rdy[1]), .data_read(rd[1])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put(input int d, input int i, input logic [SAW-1:0] a, input logic c);
    addr[d][i*SAW +: SAW] = a;
    cs[d][i] = c;
  endtask

  // Wait (bounded) for a request, check its address, then ack and return data
  task automatic serve(input int d, input logic [15:0] data, input logic [21:0] exp, input string tag);
    for (int k = 0; k < 20; k++) begin
      if (req[d]) break;
      step();
    end
    chk({tag, "_req"}, 64'(req[d]), 64'd1);
    chk({tag, "_addr"}, 64'(sa[d]), 64'(exp));
    ack[d] = 1'b1;
    step();
    ack[d] = 1'b0;
    rdy[d] = 1'b1;
    rd[d]  = data;
    step();
    rdy[d] = 1'b0;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      cs[d] = '0; addr[d] = '0; dl[d] = 1'b0; ack[d] = 1'b0; rdy[d] = 1'b0; rd[d] = '0;
    end
    step();
    step();
    chk("rst_req", 64'(req[0]), 64'd0);
    chk("rst_addr", 64'(sa[0]), 64'd0);
    chk("rst_ok", 64'(ok[0]), 64'd0);
    chk("rst_dout", dout[0], 64'd0);
    chk("rst_req_fp", 64'(req[1]), 64'd0);
    rst = 1'b0;
    step();

    // 16-bit miss with offset, request held until ack, then hit
    put(0, 0, 'h20, 1'b1);
    step();
    chk("t1_req", 64'(req[0]), 64'd1);
    chk("t1_addr", 64'(sa[0]), 64'h1020);
    step(); step(); step();
    chk("t1_hold", 64'(req[0]), 64'd1);
    chk("t1_hold_addr", 64'(sa[0]), 64'h1020);
    ack[0] = 1'b1;
    step();
    ack[0] = 1'b0;
    chk("t1_ack_drop", 64'(req[0]), 64'd0);
    rdy[0] = 1'b1; rd[0] = 16'hBEEF;
    step();
    rdy[0] = 1'b0;
    chk("t1_ok", 64'(ok[0][0]), 64'd1);
    chk("t1_dout", 64'(dout[0][15:0]), 64'hBEEF);
    cs[0][0] = 1'b0;
    step();
    chk("t1_cs_low", 64'(ok[0][0]), 64'd0);
    cs[0][0] = 1'b1;
    step();
    chk("t1_hit", 64'(ok[0][0]), 64'd1);
    chk("t1_hit_noreq", 64'(req[0]), 64'd0);
    cs[0][0] = 1'b0;

    // 8-bit slot: high byte, then low byte of the same word as a hit
    put(0, 1, 'h41, 1'b1);
    serve(0, 16'h12AB, 22'h002020, "t2_miss");
    chk("t2_ok", 64'(ok[0][1]), 64'd1);
    chk("t2_dout_hi", 64'(dout[0][31:16]), 64'h0012);
    put(0, 1, 'h40, 1'b1);
    step();
    chk("t2_dout_lo", 64'(dout[0][31:16]), 64'h00AB);
    chk("t2_ok_lo", 64'(ok[0][1]), 64'd1);
    chk("t2_noreq", 64'(req[0]), 64'd0);
    cs[0][1] = 1'b0;

    // Reset while in REQ drops the request immediately and clears outputs
    put(0, 2, 'h5, 1'b1);
    step();
    chk("t6_req", 64'(req[0]), 64'd1);
    rst = 1'b1;
    #1;
    chk("t6_rst_req", 64'(req[0]), 64'd0);
    chk("t6_rst_addr", 64'(sa[0]), 64'd0);
    chk("t6_rst_dout", dout[0], 64'd0);
    cs[0] = '0;
    step();
    rst = 1'b0;
    step();

    // Round-robin: all four miss, slot 0 re-miss is served after 1, 2, 3
    put(0, 0, 'h10, 1'b1);
    put(0, 1, 'h22, 1'b1);
    put(0, 2, 'h30, 1'b1);
    put(0, 3, 'h20, 1'b1);
    serve(0, 16'hA000, 22'h001010, "rr_g0");
    put(0, 0, 'h11, 1'b1);
    serve(0, 16'hA101, 22'h002011, "rr_g1");
    serve(0, 16'hA202, 22'h003030, "rr_g2");
    serve(0, 16'hA303, 22'h000010, "rr_g3");
    serve(0, 16'hB000, 22'h001011, "rr_g0b");
    chk("rr_ok", 64'(ok[0]), 64'hF);
    chk("rr_dout", dout[0], {16'hA303, 16'hA202, 16'h0001, 16'hB000});

    // Fixed priority: slot 0 re-miss wins again before 1, 2, 3
    put(1, 0, 'h10, 1'b1);
    put(1, 1, 'h11, 1'b1);
    put(1, 2, 'h12, 1'b1);
    put(1, 3, 'h13, 1'b1);
    serve(1, 16'h1111, 22'h000010, "fp_g0");
    put(1, 0, 'h20, 1'b1);
    serve(1, 16'h2222, 22'h000020, "fp_g0b");
    serve(1, 16'h3333, 22'h000011, "fp_g1");
    serve(1, 16'h4444, 22'h000012, "fp_g2");
    serve(1, 16'h5555, 22'h000013, "fp_g3");
    chk("fp_ok", 64'(ok[1]), 64'hF);
    chk("fp_dout", dout[1], {16'h5555, 16'h4444, 16'h3333, 16'h2222});

    // Address change during WAIT: old tag filled, no ok, then re-request
    cs[0] = '0;
    put(0, 2, 'h40, 1'b1);
    step();
    chk("t4_req", 64'(req[0]), 64'd1);
    chk("t4_addr", 64'(sa[0]), 64'h3040);
    ack[0] = 1'b1;
    step();
    ack[0] = 1'b0;
    put(0, 2, 'h41, 1'b1);
    step();
    rdy[0] = 1'b1; rd[0] = 16'hC000;
    step();
    rdy[0] = 1'b0;
    chk("t4_ok_old", 64'(ok[0][2]), 64'd0);
    step();
    chk("t4_rereq", 64'(req[0]), 64'd1);
    chk("t4_ok_wait", 64'(ok[0][2]), 64'd0);
    serve(0, 16'hC111, 22'h003041, "t4_new");
    chk("t4_ok_new", 64'(ok[0][2]), 64'd1);
    chk("t4_dout_new", 64'(dout[0][47:32]), 64'hC111);

    // Download during WAIT: fill discarded, no requests, then full refetch
    put(0, 0, 'h11, 1'b1);
    put(0, 3, 'h20, 1'b1);
    put(0, 2, 'h50, 1'b1);
    step();
    chk("t5_req", 64'(req[0]), 64'd1);
    chk("t5_addr", 64'(sa[0]), 64'h3050);
    chk("t5_hits", 64'(ok[0]), 64'h9);
    ack[0] = 1'b1;
    step();
    ack[0] = 1'b0;
    dl[0] = 1'b1;
    step();
    chk("t5_dl_ok", 64'(ok[0]), 64'h0);
    dl[0] = 1'b0;
    rdy[0] = 1'b1; rd[0] = 16'hDDDD;
    step();
    rdy[0] = 1'b0;
    chk("t5_discard", 64'(ok[0]), 64'h0);
    dl[0] = 1'b1;
    step();
    step();
    chk("t5_dl_noreq", 64'(req[0]), 64'd0);
    dl[0] = 1'b0;
    serve(0, 16'hE333, 22'h000010, "t5_rf3");
    serve(0, 16'hE000, 22'h001011, "t5_rf0");
    serve(0, 16'hE222, 22'h003050, "t5_rf2");
    chk("t5_ok_all", 64'(ok[0]), 64'hD);
    chk("t5_dout2", 64'(dout[0][47:32]), 64'hE222);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jtframe_romarb.md
# jtframe_romarb

Parametrised N-slot SDRAM read arbiter that replaces the fixed nine-slot ROM multiplexer in game top levels. Each slot has its own address width, data width (8 or 16 bits), SDRAM offset and a one-word cache. Misses are served through a single request/ack/ready SDRAM read port, using fixed-priority or round-robin arbitration. It sits between the game subsystems (CPU ROM, GFX ROM, PCM channels) and the framework SDRAM controller. All slot access is suspended while downloading.

## Interface
Parameters:
- SLOTS, 4: number of slots, 1..16.
- SAW, 19: slot address width; every slot port carries SAW bits, and unused MSBs are tied low.
- DW8, 0: SLOTS-bit mask; a set bit i makes slot i an 8-bit slot.
- OFFSETS, 0: SLOTS×22-bit packed vector of word offsets added to each slot's word address; slot i occupies bits [22i+21:22i].
- RR, 0: arbitration mode; 0 = fixed priority with the lowest index winning, 1 = round-robin.

Ports:
- clk  in  1  system clock; every register is clocked here.
- rst  in  1  reset, asynchronous, active-high.
- downloading  in  1  ROM download in progress.
- slot_cs  in  SLOTS  per-slot read request, level.
- slot_addr  in  SLOTS×SAW  per-slot address; byte address for 8-bit slots, word address for 16-bit slots.
- slot_ok  out  SLOTS  slot_dout is valid for the current slot_addr.
- slot_dout  out  SLOTS×16  read data; 8-bit slots return the byte in [7:0] with [15:8]=0.
- sdram_req  out  1  read request, held until sdram_ack.
- sdram_addr  out  22  SDRAM word address.
- sdram_ack  in  1  controller accepted the request.
- data_rdy  in  1  data_read valid, one-cycle pulse.
- data_read  in  16  SDRAM read word.

## Operation
- Word address of slot i:
  - 8-bit slot: wa_i = addr_i >> 1.
  - 16-bit slot: wa_i = addr_i.
  - SDRAM address = wa_i + OFFSET_i, truncated to 22 bits; overflow wraps silently.
- Per-slot cache contents: valid bit, tag (word address, SAW bits), data (16 bits).
- Hit condition: cs_i & valid_i & (tag_i == wa_i).
- Miss condition: cs_i & ~hit_i.
- slot_ok_i is registered: high the cycle after a hit is seen, and low whenever cs_i is low.
- Byte select for an 8-bit slot is addr_i[0]: 0 selects data[7:0], 1 selects data[15:8]. A change of addr_i[0] only within the same word is still a hit.
- FSM states:
  - IDLE: if any slot misses and downloading=0, latch the grant index and the SDRAM address, raise sdram_req, go to REQ.
  - REQ: hold sdram_req and sdram_addr stable; on sdram_ack drop sdram_req and go to WAIT.
  - WAIT: on data_rdy write data_read into the granted slot's cache, set the tag to the latched word address and valid=1, go to IDLE.
- Arbitration happens only in IDLE.
  - RR=1: search starts at last_grant+1 and wraps to 0 after SLOTS-1.
  - RR=0: the lowest-index missing slot wins.
- cs_i dropping or addr_i changing during REQ/WAIT: the transaction still completes and the cache is filled with the latched tag. If the address changed, the next IDLE re-arbitrates it as a miss.
- downloading=1:
  - All valid bits clear, slot_ok=0, and no new request starts.
  - A transaction already in REQ/WAIT completes, but its fill is discarded (valid stays 0).
- sdram_ack and data_rdy in the same cycle while in REQ: treated as ack followed by fill; the data is written and the FSM returns to IDLE.

## Timing
- Reset values: sdram_req=0, sdram_addr=0, slot_ok=0, slot_dout=0, all valid=0, FSM=IDLE, last_grant=SLOTS-1.
- Miss latency:
  - sdram_req rises 1 cycle after cs/addr are sampled in IDLE.
  - slot_ok rises 1 cycle after data_rdy.
- Hit latency: slot_ok rises 1 cycle after cs/addr are applied.
- Back-to-back: after a fill, the next request can rise at the earliest 1 cycle after the return to IDLE, i.e. 2 cycles after data_rdy.
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and sdram_req drops asynchronously. The controller must tolerate an abandoned request.

## Structure
- Package jtframe_romarb_pkg holds:
  - the state enum (IDLE, REQ, WAIT);
  - localparam SDRAM_AW=22;
  - an offset-extraction function for the packed OFFSETS vector.
- Sub-module jtframe_romarb_slot, one instance per slot, handles:
  - the cache registers, hit compare and slot_ok register;
  - byte selection and the fill write.
- The top level keeps the FSM, the arbiter and the address adder/mux.

## Test plan
- Single slot, SLOTS=1, OFFSET=0x1000, 16-bit, addr=0x20: sdram_addr=0x1020 and req holds until ack. data_rdy with 0xBEEF → slot_ok the next cycle, dout=0xBEEF; the same addr again → ok after 1 cycle with no sdram_req.
- 8-bit slot, addr=0x41 then 0x40, data 0x12AB: dout=0x0012, then 0x00AB on a hit with no second request.
- RR=1, SLOTS=4, all four missing at once: grants go 0,1,2,3. Slot 0 re-missing after its fill is served only after 1, 2 and 3. With RR=0 in the same pattern, slot 0 re-wins first.
- Address change during WAIT on slot 2: the old tag is filled and a new request is issued for the new address. slot_ok stays 0 until the new fill.
- downloading pulsed high while in WAIT: the fill is discarded, all slot_ok=0 and no requests are issued. Once downloading=0, every active slot refetches.
- rst asserted in REQ: sdram_req=0 in the same cycle and all outputs take their reset values. The first miss after reset issues a fresh request.
